// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU data-bus responder.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] BUS_IDLE_DATA = 32'hFFFF_FFFF;
    localparam int          CNT_W         = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-port bus: request from the CPU, response from the memory side.
interface data_mem_responder_if;

    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic        CS;
    logic        WE;
    logic [31:0] Data_BUS_READ;
    logic        Ready;
    logic        Err;

    modport master (
        output ADDR, Data_BUS_WRITE, CS, WE,
        input  Data_BUS_READ, Ready, Err
    );

    modport slave (
        input  ADDR, Data_BUS_WRITE, CS, WE,
        output Data_BUS_READ, Ready, Err
    );

endinterface

// File: rtl/data_ram.sv
// Single-port word array: synchronous write, synchronous read, no reset.
module data_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // rdata_o only moves on a read, so it holds between accesses
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts CPU requests, waits WAIT_STATES cycles,
// performs the access on entry to RESP and strobes Ready (and Err) for one cycle.
module data_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                 CLK,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus
);

    localparam int                AW      = $clog2(DEPTH);
    localparam logic [31:0]       SPAN    = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0]  WS_LOAD = CNT_W'(WAIT_STATES);

    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        // below BASE_ADDR wraps to a huge offset, so one compare covers both ends
        return (a[1:0] != 2'b00) || (off >= SPAN);
    endfunction

    function automatic logic [AW-1:0] addr_index(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_bad_q, rd_bad_d;
    logic [31:0]      addr_q, wdata_q;
    logic             we_q;

    logic [31:0]      req_addr, req_wdata;
    logic             req_we, req_err, access, ram_en;
    logic [31:0]      ram_rdata;

    // With zero wait states the access happens on the accept edge itself,
    // before the request registers hold it, so take it straight from the bus.
    assign req_addr  = (state_q == IDLE) ? bus.ADDR           : addr_q;
    assign req_wdata = (state_q == IDLE) ? bus.Data_BUS_WRITE : wdata_q;
    assign req_we    = (state_q == IDLE) ? bus.WE             : we_q;
    assign req_err   = addr_err(req_addr);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_bad_d = rd_bad_q;
        access   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.CS) begin
                    cnt_d = WS_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (access && !req_we) begin
            rd_bad_d = req_err;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_bad_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_bad_q <= rd_bad_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == IDLE && bus.CS) begin
            addr_q  <= bus.ADDR;
            wdata_q <= bus.Data_BUS_WRITE;
            we_q    <= bus.WE;
        end
    end

    // A reset held across an edge must not let a zero-wait write through
    assign ram_en = access && !req_err && !Reset;

    data_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (CLK),
        .en_i    (ram_en),
        .we_i    (req_we),
        .addr_i  (addr_index(req_addr)),
        .wdata_i (req_wdata),
        .rdata_o (ram_rdata)
    );

    assign bus.Ready         = (state_q == RESP);
    assign bus.Err           = (state_q == RESP) && addr_err(addr_q);
    assign bus.Data_BUS_READ = rd_bad_q ? BUS_IDLE_DATA : ram_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 1 and 15 wait states) and a scoreboard.
module tb_data_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] tb_addr, tb_wdata;
    logic        tb_we;
    logic        cs   [3];
    logic        rdy  [3];
    logic        errs [3];
    logic [31:0] rdat [3];

    always #5 CLK = ~CLK;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

    assign bus0.ADDR = tb_addr;  assign bus0.Data_BUS_WRITE = tb_wdata;
    assign bus0.WE   = tb_we;    assign bus0.CS = cs[0];
    assign bus1.ADDR = tb_addr;  assign bus1.Data_BUS_WRITE = tb_wdata;
    assign bus1.WE   = tb_we;    assign bus1.CS = cs[1];
    assign bus2.ADDR = tb_addr;  assign bus2.Data_BUS_WRITE = tb_wdata;
    assign bus2.WE   = tb_we;    assign bus2.CS = cs[2];

    assign rdy[0] = bus0.Ready;  assign errs[0] = bus0.Err;  assign rdat[0] = bus0.Data_BUS_READ;
    assign rdy[1] = bus1.Ready;  assign errs[1] = bus1.Err;  assign rdat[1] = bus1.Data_BUS_READ;
    assign rdy[2] = bus2.Ready;  assign errs[2] = bus2.Err;  assign rdat[2] = bus2.Data_BUS_READ;

    data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0))
        u_dut_ws0 (.CLK(CLK), .Reset(Reset), .bus(bus0));
    data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1))
        u_dut_ws1 (.CLK(CLK), .Reset(Reset), .bus(bus1));
    data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(15))
        u_dut_ws15 (.CLK(CLK), .Reset(Reset), .bus(bus2));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pulses [3] = '{0, 0, 0};

    always @(posedge CLK) cyc++;
    always @(negedge CLK) for (int i = 0; i < 3; i++) if (rdy[i] === 1'b1) pulses[i]++;

    typedef struct {
        int          d;
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        logic        idle_ok;
    } obs_t;

    exp_t        sb_q [$];
    logic [31:0] mdl_mem [3][DEPTH];
    logic [31:0] mdl_rd  [3];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 15);
    endfunction

    // Reference model: update the expected memory/read-data and queue the result
    task automatic push_exp(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd);
        exp_t        e;
        logic        bad;
        logic [31:0] off;
        int          idx;
        bad = (a[1:0] != 2'b00) || (longint'(a) < longint'(BASE)) ||
              (longint'(a) >= longint'(BASE) + 4 * DEPTH);
        off = (a - BASE) >> 2;
        idx = int'(off % DEPTH);
        if (w) begin
            if (!bad) mdl_mem[d][idx] = wd;
        end else begin
            mdl_rd[d] = bad ? 32'hFFFF_FFFF : mdl_mem[d][idx];
        end
        e.d    = d;
        e.err  = bad;
        e.lat  = ws_of(d) + 1;
        e.data = mdl_rd[d];
        sb_q.push_back(e);
    endtask

    // Present a request in an IDLE cycle, then count edges until Ready is seen
    task automatic access(input int d, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, output obs_t o);
        int n;
        @(posedge CLK); #1;
        tb_addr = a; tb_we = w; tb_wdata = wd; cs[d] = 1'b1;
        @(negedge CLK);
        o.idle_ok = (rdy[d] === 1'b0) && (errs[d] === 1'b0);
        @(posedge CLK);
        n = 0;
        @(negedge CLK);
        while (rdy[d] !== 1'b1 && n < 40) begin
            @(posedge CLK); n++; @(negedge CLK);
        end
        o.lat  = (rdy[d] === 1'b1) ? n + 1 : -1;
        o.data = rdat[d];
        o.err  = errs[d];
    endtask

    task automatic drop_cs(input int d);
        @(posedge CLK); #1;
        cs[d] = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (rdat[d] !== 32'hFFFF_FFFF || rdy[d] !== 1'b0 || errs[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_idle dut%0d cycle %0d: data=%h ready=%b err=%b, required data=ffffffff ready=0 err=0",
                             d, c, rdat[d], rdy[d], errs[d]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] ta [2] = '{32'h10, 32'h10};
        logic        tw [2] = '{1'b1, 1'b0};
        obs_t o; exp_t e;
        for (int i = 0; i < 2; i++) begin
            push_exp(1, ta[i], tw[i], 32'hDEAD_BEEF);
            access(1, ta[i], tw[i], 32'hDEAD_BEEF, o);
            drop_cs(1);
            e = sb_q.pop_front();
            n_cmp++;
            if (o.lat !== e.lat || o.err !== e.err || o.data !== e.data || o.idle_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL write_read[%0d]: got lat=%0d err=%b data=%h idle=%b, want lat=%0d err=%b data=%h idle=1",
                         i, o.lat, o.err, o.data, o.idle_ok, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
        logic        tw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] td [4] = '{32'h1, 32'h2, 32'h0, 32'h0};
        obs_t o; exp_t e;
        int t0, t1, p0;
        t0 = cyc;
        p0 = pulses[1];
        for (int i = 0; i < 4; i++) begin
            push_exp(1, ta[i], tw[i], td[i]);
            access(1, ta[i], tw[i], td[i], o);
            e = sb_q.pop_front();
            n_cmp++;
            if (o.lat !== e.lat || o.err !== e.err || o.data !== e.data || o.idle_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got lat=%0d err=%b data=%h idle=%b, want lat=%0d err=%b data=%h idle=1",
                         i, o.lat, o.err, o.data, o.idle_ok, e.lat, e.err, e.data);
            end
        end
        t1 = cyc;
        drop_cs(1);
        n_cmp++;
        if (t1 - t0 !== 12 || pulses[1] - p0 !== 4) begin
            n_fail++;
            $display("FAIL back_to_back_rate: got %0d cycles %0d ready pulses, required 12 cycles 4 pulses",
                     t1 - t0, pulses[1] - p0);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] ta [4] = '{32'h6, 32'h4, 32'h6, 32'h4};
        logic        tw [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        obs_t o; exp_t e;
        for (int i = 0; i < 4; i++) begin
            push_exp(1, ta[i], tw[i], 32'h1234_5678);
            access(1, ta[i], tw[i], 32'h1234_5678, o);
            drop_cs(1);
            e = sb_q.pop_front();
            n_cmp++;
            if (o.lat !== e.lat || o.err !== e.err || o.data !== e.data || o.idle_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL misaligned[%0d]: got lat=%0d err=%b data=%h idle=%b, want lat=%0d err=%b data=%h idle=1",
                         i, o.lat, o.err, o.data, o.idle_ok, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] top_a;
        logic [31:0] ta [5];
        logic        tw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] td [5] = '{32'h0, 32'hBAD0_BAD0, 32'h0, 32'hCAFE_F00D, 32'h0};
        obs_t o; exp_t e;
        top_a = BASE + 32'(4 * DEPTH);
        ta = '{top_a, top_a, BASE, top_a - 32'h4, top_a - 32'h4};
        for (int i = 0; i < 5; i++) begin
            push_exp(1, ta[i], tw[i], td[i]);
            access(1, ta[i], tw[i], td[i], o);
            drop_cs(1);
            e = sb_q.pop_front();
            n_cmp++;
            if (o.lat !== e.lat || o.err !== e.err || o.data !== e.data || o.idle_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL out_of_range[%0d]: got lat=%0d err=%b data=%h idle=%b, want lat=%0d err=%b data=%h idle=1",
                         i, o.lat, o.err, o.data, o.idle_ok, e.lat, e.err, e.data);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] ta [3] = '{32'h20, 32'h20, 32'h20};
        logic        tw [3] = '{1'b1, 1'b0, 1'b0};
        obs_t o; exp_t e;
        int p0;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 3; i++) begin
                if (i == 2) begin
                    p0 = pulses[d];
                    @(posedge CLK); #1;
                    tb_addr = 32'h20; tb_we = 1'b1; tb_wdata = 32'hAA; cs[d] = 1'b1;
                    if (ws_of(d) == 0) begin
                        Reset = 1'b1;
                        @(posedge CLK); #1;
                        cs[d] = 1'b0; Reset = 1'b0;
                    end else begin
                        @(posedge CLK); #2;
                        Reset = 1'b1; cs[d] = 1'b0;
                        #2 Reset = 1'b0;
                    end
                    repeat (ws_of(d) + 4) @(posedge CLK);
                    @(negedge CLK); #1;
                    n_cmp++;
                    if (pulses[d] !== p0 || rdat[d] !== 32'hFFFF_FFFF) begin
                        n_fail++;
                        $display("FAIL reset_abort dut%0d: got %0d ready pulses data=%h, required 0 pulses data=ffffffff",
                                 d, pulses[d] - p0, rdat[d]);
                    end
                    for (int k = 0; k < 3; k++) mdl_rd[k] = 32'hFFFF_FFFF;
                end
                push_exp(d, ta[i], tw[i], 32'h55);
                access(d, ta[i], tw[i], 32'h55, o);
                drop_cs(d);
                e = sb_q.pop_front();
                n_cmp++;
                if (o.lat !== e.lat || o.err !== e.err || o.data !== e.data || o.idle_ok !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_abort dut%0d step%0d: got lat=%0d err=%b data=%h idle=%b, want lat=%0d err=%b data=%h idle=1",
                             d, i, o.lat, o.err, o.data, o.idle_ok, e.lat, e.err, e.data);
                end
            end
        end
    endtask

    initial begin
        Reset    = 1'b1;
        tb_addr  = '0;
        tb_wdata = '0;
        tb_we    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            cs[d]     = 1'b0;
            mdl_rd[d] = 32'hFFFF_FFFF;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_misaligned();
        test_out_of_range();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
